// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core-wide constants (datapath width).
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;
    parameter int XLEN = 32;
endpackage
`default_nettype wire

// File: rtl/reorder_commit.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_commit
//  Description : Reorder buffer with in-order commit to the architectural
//                register file. Circular buffer with head (oldest) and tail
//                (next free) pointers. Up to WIDTH allocations, completions
//                and commits per cycle. An excepting head entry flushes the
//                whole buffer and raises a one-cycle exc_valid pulse.
//  Ports       : clk, reset (async, active-low)
//                alloc_valid/alloc_wen/alloc_rd -> alloc_ready/alloc_idx
//                cmpl_valid/cmpl_idx/cmpl_data/cmpl_exc
//                arf_wen/arf_waddr/arf_wdata  (registered commit writes)
//                exc_valid/exc_idx            (registered flush pulse)
//                count                        (occupied entries)
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_commit #(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int ROB_DEPTH = 16,
    parameter int WIDTH     = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [WIDTH-1:0]                           alloc_valid,
    input  logic [WIDTH-1:0]                           alloc_wen,
    input  logic [WIDTH-1:0][4:0]                      alloc_rd,
    output logic                                       alloc_ready,
    output logic [WIDTH-1:0][$clog2(ROB_DEPTH)-1:0]    alloc_idx,
    input  logic [WIDTH-1:0]                           cmpl_valid,
    input  logic [WIDTH-1:0][$clog2(ROB_DEPTH)-1:0]    cmpl_idx,
    input  logic [WIDTH-1:0][XLEN-1:0]                 cmpl_data,
    input  logic [WIDTH-1:0]                           cmpl_exc,
    output logic [WIDTH-1:0]                           arf_wen,
    output logic [WIDTH-1:0][4:0]                      arf_waddr,
    output logic [WIDTH-1:0][XLEN-1:0]                 arf_wdata,
    output logic                                       exc_valid,
    output logic [$clog2(ROB_DEPTH)-1:0]               exc_idx,
    output logic [$clog2(ROB_DEPTH):0]                 count
);

    localparam int c_IW = $clog2(ROB_DEPTH);
    localparam int c_CW = c_IW + 1;

    // Entry state
    logic [ROB_DEPTH-1:0]    r_valid;
    logic [ROB_DEPTH-1:0]    r_done;
    logic [ROB_DEPTH-1:0]    r_exc;
    logic [ROB_DEPTH-1:0]    r_wen;
    logic [4:0]              r_rd   [ROB_DEPTH];
    logic [XLEN-1:0]         r_data [ROB_DEPTH];

    logic [c_IW-1:0]         r_head;
    logic [c_IW-1:0]         r_tail;
    logic [c_CW-1:0]         r_count;

    logic [WIDTH-1:0]            r_arf_wen;
    logic [WIDTH-1:0][4:0]       r_arf_waddr;
    logic [WIDTH-1:0][XLEN-1:0]  r_arf_wdata;
    logic                        r_exc_valid;
    logic [c_IW-1:0]             r_exc_idx;

    logic [c_CW-1:0]             w_free;
    logic                        w_ready;
    logic                        w_flush;
    logic [WIDTH-1:0][c_IW-1:0]  w_aidx;
    logic [WIDTH-1:0][c_IW-1:0]  w_cidx;
    logic [WIDTH-1:0]            w_take;
    logic [WIDTH-1:0]            w_cmt;
    logic [WIDTH-1:0]            w_arf_en;
    logic [c_CW-1:0]             w_nalloc;
    logic [c_CW-1:0]             w_ncmt;
    logic                        w_arun;
    logic                        w_crun;

    always_comb begin
        w_free   = c_CW'(ROB_DEPTH) - r_count;
        w_ready  = (w_free >= c_CW'(WIDTH));
        w_flush  = r_valid[r_head] & r_done[r_head] & r_exc[r_head];
        w_aidx   = '0;
        w_cidx   = '0;
        w_take   = '0;
        w_cmt    = '0;
        w_arf_en = '0;
        w_nalloc = '0;
        w_ncmt   = '0;

        for (int i = 0; i < WIDTH; i++) begin
            w_aidx[i] = r_tail + c_IW'(i);
            w_cidx[i] = r_head + c_IW'(i);
        end

        // Slots are taken as a contiguous prefix: a gap stops allocation,
        // so a request only on a higher slot is ignored.
        w_arun = w_ready & ~w_flush;
        for (int i = 0; i < WIDTH; i++) begin
            w_take[i] = w_arun & alloc_valid[i];
            w_arun    = w_take[i];
            if (w_take[i]) w_nalloc = w_nalloc + c_CW'(1);
        end

        // In-order commit: each slot needs every older slot to commit too.
        // An excepting entry never commits; it flushes once it is head.
        w_crun = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_cmt[i] = w_crun & r_valid[w_cidx[i]] & r_done[w_cidx[i]]
                     & ~r_exc[w_cidx[i]];
            w_crun   = w_cmt[i];
            if (w_cmt[i]) w_ncmt = w_ncmt + c_CW'(1);
        end

        // A register written by a younger committing slot suppresses the
        // older write so the register file ends with the youngest value.
        for (int i = 0; i < WIDTH; i++) begin
            w_arf_en[i] = w_cmt[i] & r_wen[w_cidx[i]];
            for (int j = i + 1; j < WIDTH; j++) begin
                if (w_cmt[j] && r_wen[w_cidx[j]] &&
                    (r_rd[w_cidx[j]] == r_rd[w_cidx[i]]))
                    w_arf_en[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= '0;
            r_done      <= '0;
            r_exc       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_arf_wen   <= '0;
            r_arf_waddr <= '0;
            r_arf_wdata <= '0;
            r_exc_valid <= 1'b0;
            r_exc_idx   <= '0;
        end else begin
            r_arf_wen   <= w_arf_en;
            r_exc_valid <= w_flush;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_arf_en[i]) begin
                    r_arf_waddr[i] <= r_rd[w_cidx[i]];
                    r_arf_wdata[i] <= r_data[w_cidx[i]];
                end
            end
            if (w_flush) begin
                r_valid   <= '0;
                r_tail    <= r_head;
                r_count   <= '0;
                r_exc_idx <= r_head;
            end else begin
                // Later slot overrides earlier one on equal indices.
                for (int i = 0; i < WIDTH; i++) begin
                    if (cmpl_valid[i] && r_valid[cmpl_idx[i]]) begin
                        r_done[cmpl_idx[i]] <= 1'b1;
                        r_exc[cmpl_idx[i]]  <= cmpl_exc[i];
                    end
                end
                for (int i = 0; i < WIDTH; i++) begin
                    if (w_cmt[i]) r_valid[w_cidx[i]] <= 1'b0;
                end
                for (int i = 0; i < WIDTH; i++) begin
                    if (w_take[i]) begin
                        r_valid[w_aidx[i]] <= 1'b1;
                        r_done[w_aidx[i]]  <= 1'b0;
                        r_exc[w_aidx[i]]   <= 1'b0;
                    end
                end
                r_head  <= r_head + w_ncmt[c_IW-1:0];
                r_tail  <= r_tail + w_nalloc[c_IW-1:0];
                r_count <= r_count + w_nalloc - w_ncmt;
            end
        end
    end

    // Payload storage; only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (w_take[i]) begin
                r_rd[w_aidx[i]]  <= alloc_rd[i];
                r_wen[w_aidx[i]] <= alloc_wen[i];
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (!w_flush && cmpl_valid[i] && r_valid[cmpl_idx[i]])
                r_data[cmpl_idx[i]] <= cmpl_data[i];
        end
    end

    assign alloc_ready = w_ready;
    assign alloc_idx   = w_aidx;
    assign arf_wen     = r_arf_wen;
    assign arf_waddr   = r_arf_waddr;
    assign arf_wdata   = r_arf_wdata;
    assign exc_valid   = r_exc_valid;
    assign exc_idx     = r_exc_idx;
    assign count       = r_count;

endmodule
`default_nettype wire
